gauss_noise_gen: RTL and testbench
==================================

# gauss_noise_gen

Hardware additive-white-Gaussian-noise source for channel-emulation and BER test benches. Two independent Tausworthe (taus88) uniform generators each feed a central-limit-theorem (CLT) accumulator that sums 12 eight-bit uniforms. The result is two uncorrelated, approximately N(0,1) samples in signed Q8.8 format. The block sits at the head of the noise path; downstream logic scales the samples and adds them to the signal.

## Interface
- Parameters: none. Output width is fixed at 16 bits; the format is fixed at Q8.8.
- iClk  in  1  — single clock; all logic is rising-edge.
- iRst  in  1  — reset. Synchronous, active-low.
- iUrng_seed1..3  in  32 each  — state seeds s1, s2, s3 for URNG A (channel 1). Sampled only while reset is asserted.
- iUrng_seed4..6  in  32 each  — state seeds s1, s2, s3 for URNG B (channel 2). Sampled only while reset is asserted.
- oAwgn1  out  16  — channel-1 noise sample, signed two's complement Q8.8. Held between valid pulses.
- oAwgn2  out  16  — channel-2 noise sample, same format.
- oValid  out  1  — one-cycle pulse; oAwgn1 and oAwgn2 are new on that cycle.

## Operation
- URNG step, per cycle, with all shifts logical on 32 bits:
  - s1' = ((s1 & FFFFFFFE) << 12) ^ (((s1 << 13) ^ s1) >> 19)
  - s2' = ((s2 & FFFFFFF8) << 4) ^ (((s2 << 2) ^ s2) >> 25)
  - s3' = ((s3 & FFFFFFF0) << 17) ^ (((s3 << 3) ^ s3) >> 11)
  - word w = s1' ^ s2' ^ s3'. w is formed from the *next* state, so the first word after reset is the first taus88 output from the seeds.
- Seed sanitising at load: s1 < 2 loads 2; s2 < 8 loads 8; s3 < 16 loads 16. All other values load unchanged.
- Byte sum: b = w[7:0] + w[15:8] + w[23:16] + w[31:24], unsigned, 10 bits, range 0..1020.
- Phase counter cycles 0 → 1 → 2 → 0:
  - Phase 0: acc ← b.
  - Phase 1: acc ← acc + b.
  - Phase 2: out ← acc + b − 1530; oValid ← 1.
- Widths: acc is 12 bits unsigned. The subtraction is done in 13-bit signed, then sign-extended to 16 bits. No saturation is needed.
- Output range is −1530..+1530 (±5.98σ). Mean is 0; variance is 65535 LSB², so σ ≈ 256 LSB = 1.0 in Q8.8.
- Channels A and B run in lockstep and share the phase counter and oValid.

## Timing
- Reset (iRst = 0 at a rising edge):
  - Load sanitised seeds.
  - Phase ← 0; acc ← 0.
  - oAwgn1 = oAwgn2 = 0; oValid = 0.
- Reset held for multiple cycles: state reloads every cycle and nothing advances.
- URNG state advances on every non-reset cycle.
- First oValid comes at the 3rd rising edge after reset deasserts. Thereafter oValid rises every 3 cycles: duty 1/3, pulse width exactly 1 cycle.
- Latency: the 3 words consumed by a sample are those of the 3 cycles ending at the edge that raises oValid.
- Reset asserted mid-accumulation: the partial sum is discarded. Outputs return to 0 on the same edge. The next pulse is again the 3rd edge after release.
- Outputs change only on the valid edge or on reset. No handshake or backpressure exists: a consumer that misses a pulse loses that sample.
- Seed inputs changing outside reset have no effect.

## Structure
- Shared package `gauss_noise_pkg`:
  - taus88 masks (FFFFFFFE, FFFFFFF8, FFFFFFF0) and shift constants.
  - Minimum seeds 2, 8, 16.
  - CLT_OFFSET = 1530.
  - SAMPLE_W = 16.
  - Phase enum {PH0, PH1, PH2}.
- Sub-module `taus88_urng`: seeds, load, clk → 32-bit w. It contains the sanitising logic and the three state registers and is instantiated twice.
- The top level holds the byte adders, the accumulators, the phase counter and the output registers.

## Test plan
1. Hold iRst = 0 for 5 cycles with any seeds → oAwgn1 = oAwgn2 = 0 and oValid = 0 throughout. Release → oValid high only at edges 3, 6, 9, … after release.
2. Seeds 1999, 2995, 3666 / 3658, 1564, 4578 → first 1000 samples of each channel match a C taus88 + CLT reference bit-exactly.
3. Seeds 0, 0, 0 → sample sequence identical to seeds 2, 8, 16. Seeds 1, 7, 15 → also identical to 2, 8, 16.
4. Assert reset for 1 cycle in phase 1 → oValid = 0 and outputs = 0 on that edge. Sequence restarts identically to scenario 2.
5. Same seeds as scenario 2, 100000 samples per channel:
   - Every value lies in −1530..1530.
   - |mean| < 4 LSB; σ = 256 ± 5 LSB.
   - |corr(oAwgn1, oAwgn2)| < 0.02.
6. Set channel A seeds equal to channel B seeds → oAwgn1 == oAwgn2 on every valid cycle.

Source files
------------

// File: rtl/gauss_noise_gen_pkg.sv
// Shared constants, types and helpers for the Gaussian noise generator:
// taus88 masks/shifts, minimum seeds, CLT offset and the phase enum.
package gauss_noise_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;
  localparam int BSUM_W   = 10;
  localparam int ACC_W    = 12;
  localparam int NUM_CH   = 2;

  // taus88 component masks
  localparam logic [WORD_W-1:0] TAUS_MASK1 = 32'hFFFF_FFFE;
  localparam logic [WORD_W-1:0] TAUS_MASK2 = 32'hFFFF_FFF8;
  localparam logic [WORD_W-1:0] TAUS_MASK3 = 32'hFFFF_FFF0;

  // taus88 shift constants: A = inner left shift, B = right shift, C = masked left shift
  localparam int unsigned TAUS1_A = 13;
  localparam int unsigned TAUS1_B = 19;
  localparam int unsigned TAUS1_C = 12;
  localparam int unsigned TAUS2_A = 2;
  localparam int unsigned TAUS2_B = 25;
  localparam int unsigned TAUS2_C = 4;
  localparam int unsigned TAUS3_A = 3;
  localparam int unsigned TAUS3_B = 11;
  localparam int unsigned TAUS3_C = 17;

  // Smallest legal state per component; smaller seeds would lock the
  // component's masked bits at zero and degrade the sequence.
  localparam logic [WORD_W-1:0] TAUS_MIN1 = 32'd2;
  localparam logic [WORD_W-1:0] TAUS_MIN2 = 32'd8;
  localparam logic [WORD_W-1:0] TAUS_MIN3 = 32'd16;

  // Mean of the sum of 12 uniform bytes (12 * 127.5)
  localparam logic signed [ACC_W:0] CLT_OFFSET = 13'sd1530;

  typedef enum logic [1:0] {PH0, PH1, PH2} phase_e;

  function automatic logic [WORD_W-1:0] taus_sanitise(input logic [WORD_W-1:0] seed,
                                                       input logic [WORD_W-1:0] min_seed);
    return (seed < min_seed) ? min_seed : seed;
  endfunction

  function automatic logic [BSUM_W-1:0] byte_sum(input logic [WORD_W-1:0] w);
    return BSUM_W'(w[7:0]) + BSUM_W'(w[15:8]) + BSUM_W'(w[23:16]) + BSUM_W'(w[31:24]);
  endfunction

endpackage

// File: rtl/gauss_noise_gen_urng.sv
// taus88 uniform generator: three component state registers with seed
// sanitising on load. The word output is formed from the next state so the
// first word after load is the first taus88 output of the seeds.
module taus88_urng
  import gauss_noise_pkg::*;
(
  input  logic              clk_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] seed1_i,
  input  logic [WORD_W-1:0] seed2_i,
  input  logic [WORD_W-1:0] seed3_i,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] s1_q, s2_q, s3_q;
  logic [WORD_W-1:0] s1_d, s2_d, s3_d;

  // One taus88 step of each component from the current state
  always_comb begin
    s1_d = ((s1_q & TAUS_MASK1) << TAUS1_C) ^ (((s1_q << TAUS1_A) ^ s1_q) >> TAUS1_B);
    s2_d = ((s2_q & TAUS_MASK2) << TAUS2_C) ^ (((s2_q << TAUS2_A) ^ s2_q) >> TAUS2_B);
    s3_d = ((s3_q & TAUS_MASK3) << TAUS3_C) ^ (((s3_q << TAUS3_A) ^ s3_q) >> TAUS3_B);
  end

  assign word_o = s1_d ^ s2_d ^ s3_d;

  // State registers: reload sanitised seeds while loading, else advance
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      s1_q <= taus_sanitise(seed1_i, TAUS_MIN1);
      s2_q <= taus_sanitise(seed2_i, TAUS_MIN2);
      s3_q <= taus_sanitise(seed3_i, TAUS_MIN3);
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule

// File: rtl/gauss_noise_gen.sv
// Two-channel AWGN source: each channel sums 12 uniform bytes (three taus88
// words) and removes the mean, giving ~N(0,1) samples in signed Q8.8.
// Both channels share one phase counter and one valid pulse.
module gauss_noise_gen
  import gauss_noise_pkg::*;
(
  input  logic                iClk,
  input  logic                iRst,
  input  logic [WORD_W-1:0]   iUrng_seed1,
  input  logic [WORD_W-1:0]   iUrng_seed2,
  input  logic [WORD_W-1:0]   iUrng_seed3,
  input  logic [WORD_W-1:0]   iUrng_seed4,
  input  logic [WORD_W-1:0]   iUrng_seed5,
  input  logic [WORD_W-1:0]   iUrng_seed6,
  output logic [SAMPLE_W-1:0] oAwgn1,
  output logic [SAMPLE_W-1:0] oAwgn2,
  output logic                oValid
);

  logic                urng_load;
  logic [WORD_W-1:0]   seed1 [NUM_CH];
  logic [WORD_W-1:0]   seed2 [NUM_CH];
  logic [WORD_W-1:0]   seed3 [NUM_CH];
  phase_e              phase_q, phase_d;
  logic                valid_q, valid_d;

  // Generators reload their seeds for as long as reset is held
  assign urng_load = ~iRst;

  assign seed1[0] = iUrng_seed1;
  assign seed2[0] = iUrng_seed2;
  assign seed3[0] = iUrng_seed3;
  assign seed1[1] = iUrng_seed4;
  assign seed2[1] = iUrng_seed5;
  assign seed3[1] = iUrng_seed6;

  // Phase sequencing: the third word of each group completes a sample
  always_comb begin
    phase_d = phase_q;
    valid_d = 1'b0;
    unique case (phase_q)
      PH0: phase_d = PH1;
      PH1: phase_d = PH2;
      PH2: begin
        phase_d = PH0;
        valid_d = 1'b1;
      end
      default: phase_d = PH0;
    endcase
  end

  // Phase and valid registers
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      phase_q <= PH0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WORD_W-1:0]     word;
    logic [BSUM_W-1:0]     bsum;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [ACC_W:0]        total;
    logic signed [ACC_W:0] centred;

    taus88_urng u_urng (
      .clk_i   (iClk),
      .load_i  (urng_load),
      .seed1_i (seed1[gi]),
      .seed2_i (seed2[gi]),
      .seed3_i (seed3[gi]),
      .word_o  (word)
    );

    assign bsum = byte_sum(word);
    // Full 12-byte total fits 12 bits (max 3060); one extra bit makes it signed-safe
    assign total   = {1'b0, acc_q} + (ACC_W+1)'(bsum);
    assign centred = $signed(total) - CLT_OFFSET;

    // Accumulate over phases 0/1, emit the centred total on phase 2
    always_comb begin
      acc_d    = acc_q;
      sample_d = sample_q;
      unique case (phase_q)
        PH0: acc_d = ACC_W'(bsum);
        PH1: acc_d = acc_q + ACC_W'(bsum);
        PH2: sample_d = {{(SAMPLE_W-ACC_W-1){centred[ACC_W]}}, centred};
        default: acc_d = acc_q;
      endcase
    end

    // Accumulator and output sample registers
    always_ff @(posedge iClk) begin
      if (!iRst) begin
        acc_q    <= '0;
        sample_q <= '0;
      end else begin
        acc_q    <= acc_d;
        sample_q <= sample_d;
      end
    end
  end

  assign oAwgn1 = g_ch[0].sample_q;
  assign oAwgn2 = g_ch[1].sample_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_gauss_noise_gen.sv
// Scoreboard bench for gauss_noise_gen: a taus88 + 12-byte CLT reference
// model pushes expected samples; a monitor pops them on every valid pulse
// and also checks reset values, pulse cadence and output hold.
module tb_gauss_noise_gen;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] iUrng_seed1, iUrng_seed2, iUrng_seed3;
  logic [31:0] iUrng_seed4, iUrng_seed5, iUrng_seed6;
  logic [15:0] oAwgn1, oAwgn2;
  logic        oValid;

  gauss_noise_gen dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iUrng_seed1 (iUrng_seed1),
    .iUrng_seed2 (iUrng_seed2),
    .iUrng_seed3 (iUrng_seed3),
    .iUrng_seed4 (iUrng_seed4),
    .iUrng_seed5 (iUrng_seed5),
    .iUrng_seed6 (iUrng_seed6),
    .oAwgn1      (oAwgn1),
    .oAwgn2      (oAwgn2),
    .oValid      (oValid)
  );

  always #5 iClk = ~iClk;

  int  checks = 0;
  int  errors = 0;
  int  exp1_q[$];
  int  exp2_q[$];
  int  since_rel = 0;
  int  last1 = 0;
  int  last2 = 0;
  bit  stats_en = 1'b0;
  bit  eq_mode = 1'b0;
  real st_n, st_s1, st_s2, st_q1, st_q2, st_x;

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_real(input string name, input real got, input real lo, input real hi);
    checks++;
    if (!(got >= lo && got <= hi)) begin
      errors++;
      $display("FAIL %s got %f expected range %f..%f", name, got, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void taus_advance(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c,
                                       output logic [31:0] na, output logic [31:0] nb,
                                       output logic [31:0] nc, output int bytes);
    logic [31:0] w;
    na = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
    nb = ((b & 32'hFFFFFFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
    nc = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
    w  = na ^ nb ^ nc;
    bytes = int'(w[7:0]) + int'(w[15:8]) + int'(w[23:16]) + int'(w[31:24]);
  endfunction

  task automatic push_model(input logic [31:0] sd [6], input int n);
    logic [31:0] st [6];
    int b, t1, t2;
    for (int ch = 0; ch < 2; ch++) begin
      st[3*ch]   = (sd[3*ch]   < 32'd2)  ? 32'd2  : sd[3*ch];
      st[3*ch+1] = (sd[3*ch+1] < 32'd8)  ? 32'd8  : sd[3*ch+1];
      st[3*ch+2] = (sd[3*ch+2] < 32'd16) ? 32'd16 : sd[3*ch+2];
    end
    for (int i = 0; i < n; i++) begin
      t1 = 0;
      t2 = 0;
      for (int k = 0; k < 3; k++) begin
        taus_advance(st[0], st[1], st[2], st[0], st[1], st[2], b);
        t1 += b;
        taus_advance(st[3], st[4], st[5], st[3], st[4], st[5], b);
        t2 += b;
      end
      exp1_q.push_back(t1 - 1530);
      exp2_q.push_back(t2 - 1530);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] sd [6]);
    iUrng_seed1 = sd[0]; iUrng_seed2 = sd[1]; iUrng_seed3 = sd[2];
    iUrng_seed4 = sd[3]; iUrng_seed5 = sd[4]; iUrng_seed6 = sd[5];
  endtask

  task automatic scramble();
    iUrng_seed1 = $urandom; iUrng_seed2 = $urandom; iUrng_seed3 = $urandom;
    iUrng_seed4 = $urandom; iUrng_seed5 = $urandom; iUrng_seed6 = $urandom;
  endtask

  // Hold reset, load seeds, run n samples while scrambling seed inputs, re-enter reset
  task automatic run_seeds(input logic [31:0] dut_sd [6], input logic [31:0] mdl_sd [6],
                           input int n, input int hold);
    iRst = 1'b0;
    drive(dut_sd);
    repeat (hold) @(negedge iClk);
    exp1_q.delete();
    exp2_q.delete();
    push_model(mdl_sd, n);
    iRst = 1'b1;
    for (int c = 0; c < 3 * n; c++) begin
      @(negedge iClk);
      scramble();
    end
    iRst = 1'b0;
    check_int("sb_drain", exp1_q.size(), 0);
  endtask

  // Release, run into the second sample's phase 1, then pulse reset
  task automatic mid_reset(input logic [31:0] sd [6]);
    iRst = 1'b0;
    drive(sd);
    repeat (2) @(negedge iClk);
    exp1_q.delete();
    exp2_q.delete();
    push_model(sd, 2);
    iRst = 1'b1;
    repeat (4) @(negedge iClk);
    iRst = 1'b0;
    check_int("mid_pending", exp1_q.size(), 1);
    run_seeds(sd, sd, 100, 1);
  endtask

  // ---------------- monitor ----------------
  always @(posedge iClk) begin
    int s1, s2, e1, e2;
    #1;
    s1 = int'($signed(oAwgn1));
    s2 = int'($signed(oAwgn2));
    if (iRst === 1'b0) begin
      check_int("rst_valid", (oValid === 1'b1) ? 1 : 0, 0);
      check_int("rst_awgn1", s1, 0);
      check_int("rst_awgn2", s2, 0);
      since_rel = 0;
      last1 = 0;
      last2 = 0;
    end else begin
      since_rel++;
      check_int("valid_timing", (oValid === 1'b1) ? 1 : 0, (since_rel % 3 == 0) ? 1 : 0);
      if (oValid === 1'b1) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got valid at cycle %0d expected no sample", since_rel);
        end else begin
          e1 = exp1_q.pop_front();
          e2 = exp2_q.pop_front();
          check_int("awgn1", s1, e1);
          check_int("awgn2", s2, e2);
        end
        if (eq_mode) check_int("a_eq_b", s1, s2);
        if (stats_en) begin
          check_int("range1", (s1 >= -1530 && s1 <= 1530) ? 1 : 0, 1);
          check_int("range2", (s2 >= -1530 && s2 <= 1530) ? 1 : 0, 1);
          st_n  += 1.0;
          st_s1 += s1;
          st_s2 += s2;
          st_q1 += real'(s1) * real'(s1);
          st_q2 += real'(s2) * real'(s2);
          st_x  += real'(s1) * real'(s2);
        end
        last1 = s1;
        last2 = s2;
      end else begin
        check_int("hold1", s1, last1);
        check_int("hold2", s2, last2);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] m [6];
    real m1, m2, v1, v2, corr;

    iRst = 1'b0;
    scramble();
    st_n = 0.0; st_s1 = 0.0; st_s2 = 0.0; st_q1 = 0.0; st_q2 = 0.0; st_x = 0.0;

    // Long reset hold with random seeds, then a short run
    for (int i = 0; i < 6; i++) a[i] = $urandom;
    run_seeds(a, a, 30, 5);

    // Reference seed set
    b = '{32'd1999, 32'd2995, 32'd3666, 32'd3658, 32'd1564, 32'd4578};
    run_seeds(b, b, 1000, 2);

    // Degenerate seeds must behave like the minimum seeds
    m = '{32'd2, 32'd8, 32'd16, 32'd2, 32'd8, 32'd16};
    a = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_seeds(a, m, 200, 2);
    a = '{32'd1, 32'd7, 32'd15, 32'd1, 32'd7, 32'd15};
    run_seeds(a, m, 200, 3);

    // Reset pulse mid-accumulation, then identical restart
    mid_reset(b);

    // Distribution over a few thousand samples
    stats_en = 1'b1;
    run_seeds(b, b, 3000, 2);
    stats_en = 1'b0;
    m1 = st_s1 / st_n;
    m2 = st_s2 / st_n;
    v1 = st_q1 / st_n - m1 * m1;
    v2 = st_q2 / st_n - m2 * m2;
    corr = (st_x / st_n - m1 * m2) / $sqrt(v1 * v2);
    check_real("mean1", m1, -20.0, 20.0);
    check_real("mean2", m2, -20.0, 20.0);
    check_real("sigma1", $sqrt(v1), 240.0, 272.0);
    check_real("sigma2", $sqrt(v2), 240.0, 272.0);
    check_real("corr", corr, -0.08, 0.08);

    // Identical seeds on both channels
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom;
      a[i+3] = a[i];
    end
    eq_mode = 1'b1;
    run_seeds(a, a, 200, 2);
    eq_mode = 1'b0;

    // Further random seed sets
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) a[i] = $urandom;
      run_seeds(a, a, 100, 1 + (r % 3));
    end

    repeat (2) @(negedge iClk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
